// File: rtl/fp_f2i.sv
// Registered binary32 -> int32 converter (FCVT.W.S) with RISC-V rounding modes and flags.
// One pipeline stage: all decode/rounding is combinational ahead of the output register.
module fp_f2i (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [2:0]  frm,
  output logic [31:0] d,
  output logic        invalid,
  output logic        OF,
  output logic        UF,
  output logic        NX
);

  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  logic        sgn;
  logic [7:0]  exp_f;
  logic [22:0] frac;
  logic [23:0] mant;
  logic        is_nan, is_inf, is_zero;
  logic        exp_big, exp_lt_m1, exp_m1_or_more;
  logic [5:0]  shamt;
  logic [63:0] q;
  logic [32:0] int_part;
  logic        g_bit, s_bit, inc;
  logic [32:0] rnd;
  logic        ovf;

  logic [31:0] d_d, d_q;
  logic        inv_d, inv_q, of_d, of_q, uf_d, uf_q, nx_d, nx_q;

  assign sgn   = a[31];
  assign exp_f = a[30:23];
  assign frac  = a[22:0];
  assign mant  = {(exp_f != 8'd0), frac};

  assign is_nan  = (exp_f == 8'hFF) && (frac != 23'd0);
  assign is_inf  = (exp_f == 8'hFF) && (frac == 23'd0);
  assign is_zero = (exp_f == 8'd0) && (frac == 23'd0);

  // Unbiased exponent ranges: E > 31 always overflows, E < -1 only leaves sticky.
  assign exp_big        = exp_f > 8'd158;
  assign exp_m1_or_more = exp_f >= 8'd126;
  assign exp_lt_m1      = !exp_m1_or_more;

  // For E in [-1, 31], q = M << (E+1) holds |a| with 24 fraction bits.
  always_comb begin
    shamt = 6'd0;
    if (exp_m1_or_more && !exp_big) shamt = 6'(exp_f - 8'd126);
  end

  assign q = {40'd0, mant} << shamt;

  always_comb begin
    int_part = 33'd0;
    g_bit    = 1'b0;
    s_bit    = 1'b0;
    if (exp_lt_m1) begin
      s_bit = !is_zero;
    end else begin
      int_part = q[56:24];
      g_bit    = q[23];
      s_bit    = |q[22:0];
    end
  end

  always_comb begin
    unique case (frm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sgn & (g_bit | s_bit);
      RM_RUP:  inc = ~sgn & (g_bit | s_bit);
      RM_RMM:  inc = g_bit;
      default: inc = g_bit & (s_bit | int_part[0]);
    endcase
  end

  assign rnd = int_part + {32'd0, inc};
  assign ovf = exp_big || (sgn ? (rnd > 33'h0_8000_0000) : (rnd > 33'h0_7FFF_FFFF));

  always_comb begin
    d_d   = 32'd0;
    inv_d = 1'b0;
    of_d  = 1'b0;
    uf_d  = 1'b0;
    nx_d  = 1'b0;
    if (is_nan) begin
      d_d   = 32'h7FFF_FFFF;
      inv_d = 1'b1;
    end else if (is_inf) begin
      d_d   = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
      inv_d = 1'b1;
    end else if (is_zero) begin
      d_d = 32'd0;
    end else if (ovf) begin
      d_d   = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
      inv_d = 1'b1;
      of_d  = 1'b1;
    end else begin
      d_d  = sgn ? (32'd0 - rnd[31:0]) : rnd[31:0];
      nx_d = g_bit | s_bit;
      uf_d = exp_f < 8'd127;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q   <= 32'd0;
      inv_q <= 1'b0;
      of_q  <= 1'b0;
      uf_q  <= 1'b0;
      nx_q  <= 1'b0;
    end else begin
      d_q   <= d_d;
      inv_q <= inv_d;
      of_q  <= of_d;
      uf_q  <= uf_d;
      nx_q  <= nx_d;
    end
  end

  assign d       = d_q;
  assign invalid = inv_q;
  assign OF      = of_q;
  assign UF      = uf_q;
  assign NX      = nx_q;

endmodule

// File: tb/tb_fp_f2i.sv
// Directed bench for fp_f2i: hand-computed results and flags, checked one edge after each input.
module tb_fp_f2i;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a;
  logic [2:0]  frm;
  logic [31:0] d;
  logic        invalid, OF, UF, NX;

  int passed = 0;
  int total  = 0;

  fp_f2i dut (
    .clk(clk), .rst(rst), .a(a), .frm(frm),
    .d(d), .invalid(invalid), .OF(OF), .UF(UF), .NX(NX)
  );

  always #5 clk = ~clk;

  // flags packed as {invalid, OF, UF, NX}
  task automatic check(input string tag, input logic [31:0] exp_d, input logic [3:0] exp_f);
    logic [3:0] got_f;
    got_f = {invalid, OF, UF, NX};
    total++;
    assert (d === exp_d) passed++;
    else $error("FAIL %s d: got %h expected %h", tag, d, exp_d);
    total++;
    assert (got_f === exp_f) passed++;
    else $error("FAIL %s flags{inv,OF,UF,NX}: got %b expected %b", tag, got_f, exp_f);
  endtask

  task automatic step(input string tag, input logic [31:0] av, input logic [2:0] fv,
                      input logic [31:0] exp_d, input logic [3:0] exp_f);
    @(negedge clk);
    a   = av;
    frm = fv;
    @(posedge clk);
    #1;
    check(tag, exp_d, exp_f);
  endtask

  initial begin
    rst = 1'b1;
    a   = 32'h4026_6666;
    frm = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'd0, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    // RNE
    step("rne_2.6",  32'h4026_6666, 3'b000, 32'd3,         4'b0001);
    step("rne_2.5",  32'h4020_0000, 3'b000, 32'd2,         4'b0001);
    step("rne_2.4",  32'h4019_999A, 3'b000, 32'd2,         4'b0001);
    step("rne_3.5",  32'h4060_0000, 3'b000, 32'd4,         4'b0001);
    step("rne_-2.5", 32'hC020_0000, 3'b000, 32'hFFFF_FFFE, 4'b0001);
    step("rne_-3.5", 32'hC060_0000, 3'b000, 32'hFFFF_FFFC, 4'b0001);
    step("rne_-3.4", 32'hC059_999A, 3'b000, 32'hFFFF_FFFD, 4'b0001);
    step("frm111_2.5", 32'h4020_0000, 3'b111, 32'd2,       4'b0001);
    // RMM / RTZ
    step("rmm_2.5",  32'h4020_0000, 3'b100, 32'd3,         4'b0001);
    step("rmm_-2.5", 32'hC020_0000, 3'b100, 32'hFFFF_FFFD, 4'b0001);
    step("rmm_3.4",  32'h4059_999A, 3'b100, 32'd3,         4'b0001);
    step("rtz_2.6",  32'h4026_6666, 3'b001, 32'd2,         4'b0001);
    step("rtz_-3.6", 32'hC066_6666, 3'b001, 32'hFFFF_FFFD, 4'b0001);
    // RDN / RUP
    step("rdn_2.6",  32'h4026_6666, 3'b010, 32'd2,         4'b0001);
    step("rdn_-2.4", 32'hC019_999A, 3'b010, 32'hFFFF_FFFD, 4'b0001);
    step("rup_2.4",  32'h4019_999A, 3'b011, 32'd3,         4'b0001);
    step("rup_-2.6", 32'hC026_6666, 3'b011, 32'hFFFF_FFFE, 4'b0001);
    step("rup_-3.4", 32'hC059_999A, 3'b011, 32'hFFFF_FFFD, 4'b0001);
    // exact and small
    step("exact_3.0",  32'h4040_0000, 3'b000, 32'd3,       4'b0000);
    step("rne_0.5",    32'h3F00_0000, 3'b000, 32'd0,       4'b0011);
    step("rup_subnorm",32'h0000_0001, 3'b011, 32'd1,       4'b0011);
    step("neg_zero",   32'h8000_0000, 3'b000, 32'd0,       4'b0000);
    step("rdn_-0.25",  32'hBE80_0000, 3'b010, 32'hFFFF_FFFF, 4'b0011);
    // invalid / range
    step("nan",        32'h7FC0_0000, 3'b000, 32'h7FFF_FFFF, 4'b1000);
    step("pos_inf",    32'h7F80_0000, 3'b000, 32'h7FFF_FFFF, 4'b1000);
    step("neg_inf",    32'hFF80_0000, 3'b000, 32'h8000_0000, 4'b1000);
    step("pos_2^31",   32'h4F00_0000, 3'b000, 32'h7FFF_FFFF, 4'b1100);
    step("neg_2^31",   32'hCF00_0000, 3'b000, 32'h8000_0000, 4'b0000);
    step("neg_ovf",    32'hCF00_0001, 3'b000, 32'h8000_0000, 4'b1100);
    step("huge",       32'h5F00_0000, 3'b001, 32'h7FFF_FFFF, 4'b1100);
    step("rup_max",    32'h4EFF_FFFF, 3'b011, 32'h7FFF_FF80, 4'b0000);

    // reset overrides an in-flight conversion, then release yields result one edge later
    @(negedge clk);
    rst = 1'b1;
    a   = 32'h4026_6666;
    frm = 3'b000;
    @(posedge clk);
    #1;
    check("rst_hold", 32'd0, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_release", 32'd3, 4'b0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
